// File: rtl/fpadd_sched.sv
// Round-robin front end for a single shared fpadd: grants one requester at a time,
// pulses start, waits for done (or gives up after TIMEOUT cycles) and returns a tagged result.
module fpadd_sched #(
    parameter int NREQ    = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 511,
    parameter int TO_W    = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [31:0]          resp_sum,
    output logic [ID_W-1:0]      resp_id,
    output logic                 resp_err,
    output logic                 busy,
    output logic                 fp_start,
    output logic [31:0]          fp_a,
    output logic [31:0]          fp_b,
    input  logic [31:0]          fp_sum,
    input  logic                 fp_done
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                 state, state_nxt;
    logic [ID_W-1:0]        ptr, id_q, gnt_id;
    logic [TO_W-1:0]        cnt;
    logic                   gnt_vld;
    logic                   timeout_hit;
    logic [2*NREQ-1:0]      dbl;
    logic [NREQ-1:0]        rot;
    logic [ID_W:0]          off, gnt_sum;
    logic [NREQ-1:0][31:0]  a_v, b_v;

    assign a_v         = req_a;
    assign b_v         = req_b;
    assign timeout_hit = (cnt == TO_W'(TIMEOUT - 1));

    // Rotate valids so bit 0 is ptr; the lowest set bit is the winner.
    assign dbl = {req_valid, req_valid} >> ptr;
    assign rot = dbl[NREQ-1:0];

    always_comb begin
        gnt_vld = 1'b0;
        off     = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                gnt_vld = 1'b1;
                off     = (ID_W+1)'(k);
            end
        end
    end

    assign gnt_sum = {1'b0, ptr} + off;
    assign gnt_id  = (gnt_sum >= (ID_W+1)'(NREQ)) ? ID_W'(gnt_sum - (ID_W+1)'(NREQ))
                                                  : ID_W'(gnt_sum);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gnt_vld) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (fp_done || timeout_hit) state_nxt = RESP;
            RESP:    if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // reset gates req_ready so nothing looks accepted while the block is held in reset.
    always_comb begin
        busy      = (state != IDLE);
        req_ready = '0;
        if (state == IDLE && gnt_vld && reset)
            req_ready = NREQ'(1) << gnt_id;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr        <= '0;
            id_q       <= '0;
            cnt        <= '0;
            fp_start   <= 1'b0;
            fp_a       <= '0;
            fp_b       <= '0;
            resp_valid <= 1'b0;
            resp_sum   <= '0;
            resp_id    <= '0;
            resp_err   <= 1'b0;
        end else begin
            fp_start <= 1'b0;
            case (state)
                IDLE: if (gnt_vld) begin
                    fp_a     <= a_v[gnt_id];
                    fp_b     <= b_v[gnt_id];
                    id_q     <= gnt_id;
                    fp_start <= 1'b1;
                end
                ISSUE: cnt <= '0;
                WAIT: begin
                    if (fp_done) begin
                        resp_sum   <= fp_sum;
                        resp_err   <= 1'b0;
                        resp_id    <= id_q;
                        resp_valid <= 1'b1;
                    end else if (timeout_hit) begin
                        resp_sum   <= '0;
                        resp_err   <= 1'b1;
                        resp_id    <= id_q;
                        resp_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + TO_W'(1);
                    end
                end
                RESP: if (resp_ready) begin
                    resp_valid <= 1'b0;
                    ptr        <= (id_q == ID_W'(NREQ - 1)) ? '0 : id_q + ID_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fpadd_sched.sv
// Scoreboard bench for fpadd_sched: queued requesters, a latency-programmable fpadd stub,
// a round-robin prediction of grant order and a monitor comparing every accept and response.
module tb_fpadd_sched;
    localparam int NREQ = 4, ID_W = 2, TIMEOUT = 16, TO_W = 10;

    logic                clk = 1'b0, reset = 1'b0;
    logic [NREQ-1:0]     req_valid, req_ready;
    logic [32*NREQ-1:0]  req_a, req_b;
    logic                resp_valid, resp_ready, resp_err, busy, fp_start, fp_done;
    logic [31:0]         resp_sum, fp_a, fp_b, fp_sum;
    logic [ID_W-1:0]     resp_id;

    always #5 clk = ~clk;

    fpadd_sched #(.NREQ(NREQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_sum(resp_sum), .resp_id(resp_id), .resp_err(resp_err), .busy(busy),
        .fp_start(fp_start), .fp_a(fp_a), .fp_b(fp_b), .fp_sum(fp_sum), .fp_done(fp_done)
    );

    int total = 0, bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        total++;
        bad++;
        $display("FAIL %s", nm);
    endtask

    // Single-precision <-> real, exact for the normal values and zeros used here.
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'd0) return 0.0;
        d = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'b0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return {d[63], 31'b0};
        return {d[63], 8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
    endfunction

    typedef struct {
        logic [ID_W-1:0] id;
        logic [31:0]     sum;
        logic            err;
    } exp_t;

    logic [31:0] qa[NREQ][$], qb[NREQ][$];
    logic [31:0] sa[NREQ][$], sbv[NREQ][$], se[NREQ][$];
    exp_t        sbq[$];
    int          egq[$];
    int          rptr = 0;

    task automatic stage(input int id, input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
        sa[id].push_back(a);
        sbv[id].push_back(b);
        se[id].push_back(e);
    endtask

    task automatic stage_rand(input int id);
        int x, y;
        x = int'($urandom_range(2000)) - 1000;
        y = int'($urandom_range(2000)) - 1000;
        stage(id, r2f(real'(x)), r2f(real'(y)), r2f(real'(x + y)));
    endtask

    // Predict service order: next pending requester at or after the pointer, pointer moves past it.
    task automatic commit(input bit err);
        int   pend[NREQ];
        int   idx[NREQ];
        int   left;
        exp_t e;
        left = 0;
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = sa[i].size();
            idx[i]  = 0;
            left   += pend[i];
        end
        while (left > 0) begin
            for (int k = 0; k < NREQ; k++) begin
                int g;
                g = (rptr + k) % NREQ;
                if (idx[g] < pend[g]) begin
                    e.id  = ID_W'(g);
                    e.sum = err ? 32'h0 : se[g][idx[g]];
                    e.err = err;
                    sbq.push_back(e);
                    egq.push_back(g);
                    idx[g]++;
                    left--;
                    rptr = (g + 1) % NREQ;
                    break;
                end
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            foreach (sa[i][j]) begin
                qa[i].push_back(sa[i][j]);
                qb[i].push_back(sbv[i][j]);
            end
            sa[i].delete();
            sbv[i].delete();
            se[i].delete();
        end
    endtask

    function automatic bit pending();
        for (int i = 0; i < NREQ; i++) if (qa[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    // Requesters: present queue heads at negedge, pop what the next posedge accepts.
    logic [NREQ-1:0] hs;
    initial begin
        hs = '0; req_valid = '0; req_a = '0; req_b = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++)
                if (hs[i] && qa[i].size() > 0) begin
                    void'(qa[i].pop_front());
                    void'(qb[i].pop_front());
                end
            for (int i = 0; i < NREQ; i++) begin
                req_valid[i] = (qa[i].size() > 0);
                req_a[32*i +: 32] = 32'h0;
                req_b[32*i +: 32] = 32'h0;
                if (qa[i].size() > 0) begin
                    req_a[32*i +: 32] = qa[i][0];
                    req_b[32*i +: 32] = qb[i][0];
                end
            end
            #4;
            hs = req_valid & req_ready;
        end
    end

    // fpadd stub: start clears done, done rises after a latency and stays high.
    int          scnt = 0, lat_fix = 0;
    bit          dead = 1'b0;
    logic [31:0] ssum;
    initial begin
        fp_done = 1'b0; fp_sum = '0; ssum = '0;
        forever begin
            @(negedge clk);
            if (fp_start) begin
                fp_done = 1'b0;
                ssum    = r2f(f2r(fp_a) + f2r(fp_b));
                scnt    = dead ? 0 : (lat_fix > 0 ? lat_fix : int'($urandom_range(12, 1)));
            end else if (scnt > 0) begin
                scnt--;
                if (scnt == 0) begin
                    fp_done = 1'b1;
                    fp_sum  = ssum;
                end
            end
        end
    end

    int cyc = 0, rr_cyc = 0, starts = 0, start_cyc = 0, rise_cyc = 0;
    bit rv_q = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            #4;
            cyc++;
            if (|req_ready) rr_cyc++;
            if (|(req_valid & req_ready)) begin
                if (egq.size() == 0) fail_now("grant_unexpected");
                else chk("grant", 64'(req_ready), 64'(1) << egq.pop_front());
            end
            if (fp_start) begin
                starts++;
                start_cyc = cyc;
            end
            if (resp_valid && !rv_q) rise_cyc = cyc;
            rv_q = resp_valid;
            if (resp_valid && resp_ready) begin
                if (sbq.size() == 0) fail_now("resp_unexpected");
                else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("resp_id", 64'(resp_id), 64'(e.id));
                    chk("resp_sum", 64'(resp_sum), 64'(e.sum));
                    chk("resp_err", 64'(resp_err), 64'(e.err));
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #3;
    endtask

    task automatic drain(input bit rnd);
        int n;
        n = 0;
        while ((sbq.size() > 0 || busy || pending()) && n < 3000) begin
            tick();
            if (rnd) resp_ready = 1'($urandom_range(1));
            n++;
        end
        resp_ready = 1'b1;
        if (n >= 3000) fail_now("drain_timeout");
        tick();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'h0);
        chk({tag, "_resp_valid"}, 64'(resp_valid), 64'h0);
        chk({tag, "_resp_sum"}, 64'(resp_sum), 64'h0);
        chk({tag, "_resp_id"}, 64'(resp_id), 64'h0);
        chk({tag, "_resp_err"}, 64'(resp_err), 64'h0);
        chk({tag, "_busy"}, 64'(busy), 64'h0);
        chk({tag, "_fp_start"}, 64'(fp_start), 64'h0);
        chk({tag, "_fp_a"}, 64'(fp_a), 64'h0);
        chk({tag, "_fp_b"}, 64'(fp_b), 64'h0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          r0, s0, n;
        logic [31:0] cap_sum;
        logic [ID_W-1:0] cap_id;
        bit          stab, rdy0;
        resp_ready = 1'b0;
        repeat (2) tick();

        // Reset state with a request already pending
        stage(2, 32'h3F800000, 32'h40000000, 32'h40400000);
        commit(1'b0);
        tick();
        #1;
        check_zero("rst");
        r0 = rr_cyc; s0 = starts;
        tick();
        reset = 1'b1; resp_ready = 1'b1;
        drain(1'b0);
        chk("single_ready_cycles", 64'(rr_cyc - r0), 64'd1);
        chk("single_starts", 64'(starts - s0), 64'd1);

        // Round robin from a fresh pointer
        tick(); reset = 1'b0; rptr = 0;
        tick(); reset = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            stage_rand(i);
            stage_rand(i);
        end
        commit(1'b0);
        drain(1'b0);

        // Response backpressure with a second requester waiting
        resp_ready = 1'b0;
        stage_rand(0);
        stage_rand(1);
        commit(1'b0);
        n = 0;
        while (!resp_valid && n < 100) begin tick(); n++; end
        if (n >= 100) fail_now("bp_resp_timeout");
        cap_sum = resp_sum; cap_id = resp_id; s0 = starts;
        stab = 1'b1; rdy0 = 1'b1;
        repeat (10) begin
            tick();
            #1;
            if (!resp_valid || resp_sum !== cap_sum || resp_id !== cap_id) stab = 1'b0;
            if (req_ready !== '0) rdy0 = 1'b0;
        end
        chk("bp_stable", 64'(stab), 64'd1);
        chk("bp_req_ready_low", 64'(rdy0), 64'd1);
        chk("bp_no_start", 64'(starts - s0), 64'd0);
        tick();
        resp_ready = 1'b1;
        drain(1'b0);

        // Timeout with a dead adder, then a late done, then normal service
        dead = 1'b1;
        stage_rand(3);
        commit(1'b1);
        drain(1'b0);
        chk("timeout_edges", 64'(rise_cyc - start_cyc), 64'(TIMEOUT + 1));
        dead = 1'b0;
        stage_rand(3);
        commit(1'b0);
        drain(1'b0);
        lat_fix = 25;
        stage_rand(1);
        commit(1'b1);
        drain(1'b0);
        repeat (20) tick();
        lat_fix = 0;
        stage_rand(2);
        commit(1'b0);
        drain(1'b0);

        // Reset during WAIT discards the operation
        lat_fix = 12;
        stage_rand(3);
        commit(1'b0);
        n = 0;
        while (!busy && n < 50) begin tick(); n++; end
        if (n >= 50) fail_now("mid_busy_timeout");
        repeat (3) tick();
        chk("mid_in_wait_busy", 64'(busy), 64'd1);
        reset = 1'b0;
        #1;
        check_zero("mid");
        sbq.delete();
        rptr = 0;
        repeat (2) tick();
        reset = 1'b1;
        lat_fix = 0;
        repeat (20) tick();
        stage_rand(1);
        commit(1'b0);
        tick();
        stage_rand(0);
        commit(1'b0);
        drain(1'b0);

        // Zero operand
        stage(1, 32'h00000000, 32'hC0A00000, 32'hC0A00000);
        commit(1'b0);
        drain(1'b0);

        // Random batches under random backpressure
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NREQ; i++) begin
                int m;
                m = int'($urandom_range(3));
                for (int j = 0; j < m; j++) stage_rand(i);
            end
            commit(1'b0);
            drain(1'b1);
        end

        chk("sb_empty", 64'(sbq.size()), 64'd0);
        chk("grants_empty", 64'(egq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
